mopshub_test_sequencer: RTL and testbench
=========================================

Name: mopshub_test_sequencer

Overview:
- Sequences the MOPSHUB system-test phases that drive the data generator: optional oscillator trim, then RX test, end-wait pulse, idle gap, TX test and optional custom-message test for each CAN bus in turn.
- Replaces hand-written phase-control logic in the top-level bench with one deterministic FSM that has a per-phase watchdog.
- Sits between the MOPSHUB sign-on/status signals and the data generator's test-enable inputs.

Parameters:
N_BUSES, 2, number of buses to cycle through (1..31); bus IDs run from 1 to N_BUSES.
GAP_CYCLES, 75, idle clk_40_m cycles between the end-wait pulse and TX start (16-bit; 0 allowed).
TIMEOUT_CYCLES, 200000, watchdog limit per active phase (32-bit; must be >= 2).

Ports:
clk_40_m  in  1  sequencer clock.
rst  in  1  reset, synchronous, active-low.
start  in  1  level; sign-on indication; sampled only in IDLE.
trim_en  in  1  run the TRIM phase once, before bus 1.
adv_en  in  1  run the ADV phase after TX on each bus.
trim_done  in  1  end-of-trim pulse or level from the hub or generator.
test_rx_end  in  1  RX-test-complete pulse.
test_tx_end  in  1  TX-test-complete pulse.
costum_msg_end  in  1  custom-message-complete pulse.
osc_auto_trim  out  1  high while in TRIM.
test_rx  out  1  high while in RX.
test_tx  out  1  high while in TX.
test_advanced  out  1  high while in ADV.
endwait_all  out  1  one-cycle pulse, high in ENDWAIT.
bus_sel  out  5  bus under test (1..N_BUSES); 0 in IDLE, DONE and ERR.
busy  out  1  high in any state except IDLE, DONE and ERR.
done  out  1  one-cycle pulse, high in DONE.
error  out  1  sticky; high in ERR.
phase  out  4  state code: IDLE=0, TRIM=1, RX=2, ENDWAIT=3, GAP=4, TX=5, ADV=6, DONE=7, ERR=8.

Behaviour:
- Moore FSM. Every output is a decode of the registered state and bus counter; there is no combinational path from inputs to outputs.
- Reset (rst=0 at a clk_40_m edge): state IDLE, bus counter 0, timer 0. All outputs are 0 from that edge onward. Reset overrides any state, including mid-phase and ERR.
- Inputs are assumed synchronous to clk_40_m.
- Response latency: an end or start condition sampled at edge k produces the new state and outputs after edge k. The outgoing enable is already low in the cycle after the end pulse is sampled.
- IDLE:
  - start=1 and trim_en=1 -> TRIM.
  - start=1 and trim_en=0 -> RX with bus_sel=1.
- TRIM: trim_done=1 -> RX with bus_sel=1.
- RX: test_rx_end=1 -> ENDWAIT.
- ENDWAIT: lasts exactly 1 cycle.
  - GAP_CYCLES>0 -> GAP.
  - GAP_CYCLES=0 -> TX.
- GAP: lasts exactly GAP_CYCLES cycles, counted by the timer, then -> TX.
- TX: test_tx_end=1 and adv_en=1 -> ADV; otherwise treat as completion of the bus.
- ADV: costum_msg_end=1 -> completion of the bus.
- Completion of the bus:
  - bus_sel < N_BUSES -> bus_sel+1, go to RX.
  - bus_sel = N_BUSES -> DONE.
- DONE: 1 cycle, then -> IDLE. start is not re-sampled until IDLE. If start is still high in IDLE, a new run begins; this is intended for loop testing.
- adv_en and trim_en are sampled only at the decision points above. Changing them mid-phase has no effect on the current phase.
- Watchdog:
  - The timer clears on every state entry and increments each cycle in TRIM, RX, TX and ADV.
  - If timer = TIMEOUT_CYCLES-1 and the phase's end input is 0 -> ERR.
  - An end input in the same cycle as the timeout wins; normal transition, no error.
- ERR: all enables low, bus_sel=0, error=1. ERR is left only by reset.
- End inputs that do not belong to the current state are ignored, e.g. test_tx_end during RX, or trim_done in IDLE.
- The bus counter never wraps. It saturates at N_BUSES by construction, because DONE is taken before any increment past N_BUSES.
- Timer width is 32 bits; GAP compare uses the low 16 bits.

Test Plan:
- Bench parameters: N_BUSES=2, GAP_CYCLES=4, TIMEOUT_CYCLES=50.
- Basic run: trim_en=0, adv_en=0; start=1; RX/TX end pulses issued 10 cycles after each enable rises -> phase sequence 2,3,4×4,5,2,3,4×4,5,7,0; bus_sel 1 then 2; endwait_all high exactly 2 cycles total; done pulses once; each enable drops 1 cycle after its end pulse.
- Trim and advanced: trim_en=1, adv_en=1; trim_done at cycle 5 -> osc_auto_trim high exactly 5 cycles. Per bus: test_advanced rises the cycle after test_tx_end and falls after costum_msg_end. After 2 buses: done=1 and error=0.
- Watchdog: withhold test_tx_end on bus 2 -> test_tx high exactly 50 cycles; then phase=8, error=1, busy=0, bus_sel=0. error stays high 100 further cycles until rst=0.
- Timeout tie: assert test_rx_end exactly on cycle 50 of RX -> transition to ENDWAIT, error stays 0.
- Stray pulses: pulse test_tx_end and costum_msg_end during RX; pulse start while busy -> no state change and no second run. GAP_CYCLES=0 build -> ENDWAIT goes directly to TX.
- Reset mid-operation: rst=0 during GAP on bus 2 -> after the next edge all outputs are 0 and phase=0. With rst=1 and start=1 -> the run restarts at bus_sel=1.

Source files
------------

// File: rtl/mopshub_test_sequencer.sv
`timescale 1ns/1ps
// MOPSHUB system-test phase sequencer.
// Steps the data generator through an optional oscillator trim, then for each
// CAN bus: RX test, end-wait pulse, idle gap, TX test and an optional custom
// message test. Every active phase has a watchdog; a timeout parks the FSM in
// ERR until reset. All outputs are registered decodes of the next state, so
// there is no combinational path from inputs to outputs.
module mopshub_test_sequencer #(
    parameter int N_BUSES        = 2,
    parameter int GAP_CYCLES     = 75,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_40_m,
    input  logic       rst,
    input  logic       start,
    input  logic       trim_en,
    input  logic       adv_en,
    input  logic       trim_done,
    input  logic       test_rx_end,
    input  logic       test_tx_end,
    input  logic       costum_msg_end,
    output logic       osc_auto_trim,
    output logic       test_rx,
    output logic       test_tx,
    output logic       test_advanced,
    output logic       endwait_all,
    output logic [4:0] bus_sel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_TRIM    = 4'd1,
        S_RX      = 4'd2,
        S_ENDWAIT = 4'd3,
        S_GAP     = 4'd4,
        S_TX      = 4'd5,
        S_ADV     = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    localparam logic [4:0]  N_BUS        = 5'(N_BUSES);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          HAS_GAP      = (GAP_CYCLES > 0);

    state_t      state_q, state_d;
    logic [4:0]  bus_q, bus_d;
    logic [31:0] timer_q, timer_d;
    logic        timeout;

    logic        osc_auto_trim_q, osc_auto_trim_d;
    logic        test_rx_q, test_rx_d;
    logic        test_tx_q, test_tx_d;
    logic        test_advanced_q, test_advanced_d;
    logic        endwait_all_q, endwait_all_d;
    logic [4:0]  bus_sel_q, bus_sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [3:0]  phase_q, phase_d;

    // Next-state, bus counter and watchdog/gap timer update.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        timer_d = timer_q + 32'd1;
        timeout = (timer_q == TIMEOUT_LAST);
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                bus_d   = '0;
                if (start) begin
                    if (trim_en) begin
                        state_d = S_TRIM;
                    end else begin
                        state_d = S_RX;
                        bus_d   = 5'd1;
                    end
                end
            end
            S_TRIM: begin
                if (trim_done) begin
                    state_d = S_RX;
                    bus_d   = 5'd1;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_RX: begin
                if (test_rx_end) begin
                    state_d = S_ENDWAIT;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_ENDWAIT: begin
                timer_d = '0;
                state_d = HAS_GAP ? S_GAP : S_TX;
            end
            S_GAP: begin
                if (timer_q[15:0] == GAP_LAST) begin
                    state_d = S_TX;
                end
            end
            S_TX: begin
                if (test_tx_end) begin
                    if (adv_en) begin
                        state_d = S_ADV;
                    end else if (bus_q < N_BUS) begin
                        state_d = S_RX;
                        bus_d   = bus_q + 5'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_ADV: begin
                if (costum_msg_end) begin
                    if (bus_q < N_BUS) begin
                        state_d = S_RX;
                        bus_d   = bus_q + 5'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                timer_d = '0;
                bus_d   = '0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                timer_d = '0;
                bus_d   = '0;
            end
            default: begin
                timer_d = '0;
                bus_d   = '0;
                state_d = S_ERR;
            end
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // Output decode of the upcoming state so outputs change together with it.
    always_comb begin
        osc_auto_trim_d = (state_d == S_TRIM);
        test_rx_d       = (state_d == S_RX);
        test_tx_d       = (state_d == S_TX);
        test_advanced_d = (state_d == S_ADV);
        endwait_all_d   = (state_d == S_ENDWAIT);
        done_d          = (state_d == S_DONE);
        error_d         = (state_d == S_ERR);
        busy_d          = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        bus_sel_d       = busy_d ? bus_d : 5'd0;
        phase_d         = state_d;
    end

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            bus_q           <= '0;
            timer_q         <= '0;
            osc_auto_trim_q <= 1'b0;
            test_rx_q       <= 1'b0;
            test_tx_q       <= 1'b0;
            test_advanced_q <= 1'b0;
            endwait_all_q   <= 1'b0;
            bus_sel_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            phase_q         <= '0;
        end else begin
            state_q         <= state_d;
            bus_q           <= bus_d;
            timer_q         <= timer_d;
            osc_auto_trim_q <= osc_auto_trim_d;
            test_rx_q       <= test_rx_d;
            test_tx_q       <= test_tx_d;
            test_advanced_q <= test_advanced_d;
            endwait_all_q   <= endwait_all_d;
            bus_sel_q       <= bus_sel_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            phase_q         <= phase_d;
        end
    end

    assign osc_auto_trim = osc_auto_trim_q;
    assign test_rx       = test_rx_q;
    assign test_tx       = test_tx_q;
    assign test_advanced = test_advanced_q;
    assign endwait_all   = endwait_all_q;
    assign bus_sel       = bus_sel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign phase         = phase_q;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
`timescale 1ns/1ps
// Bench for the MOPSHUB test sequencer. The expected output set for each
// cycle comes from the phase the bench believes the run is in, derived from
// the phase schedule the bench itself drives.
module tb_mopshub_test_sequencer;

    localparam int NB  = 2;
    localparam int GAP = 4;
    localparam int TO  = 50;

    logic clk_40_m = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, trim_en = 1'b0, adv_en = 1'b0;
    logic trim_done = 1'b0, test_rx_end = 1'b0, test_tx_end = 1'b0, costum_msg_end = 1'b0;
    logic osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all, busy, done, error;
    logic [4:0] bus_sel;
    logic [3:0] phase;

    logic g_start = 1'b0, g_rx_end = 1'b0, g_tx_end = 1'b0, g_zero = 1'b0;
    logic g_osc, g_rx, g_tx, g_adv, g_endw, g_busy, g_done, g_err;
    logic [4:0] g_bus;
    logic [3:0] g_phase;

    int checks = 0;
    int errors = 0;

    always #12 clk_40_m = ~clk_40_m;

    mopshub_test_sequencer #(.N_BUSES(NB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk_40_m(clk_40_m), .rst(rst), .start(start), .trim_en(trim_en), .adv_en(adv_en),
        .trim_done(trim_done), .test_rx_end(test_rx_end), .test_tx_end(test_tx_end),
        .costum_msg_end(costum_msg_end), .osc_auto_trim(osc_auto_trim), .test_rx(test_rx),
        .test_tx(test_tx), .test_advanced(test_advanced), .endwait_all(endwait_all),
        .bus_sel(bus_sel), .busy(busy), .done(done), .error(error), .phase(phase));

    mopshub_test_sequencer #(.N_BUSES(NB), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_g0 (
        .clk_40_m(clk_40_m), .rst(rst), .start(g_start), .trim_en(g_zero), .adv_en(g_zero),
        .trim_done(g_zero), .test_rx_end(g_rx_end), .test_tx_end(g_tx_end),
        .costum_msg_end(g_zero), .osc_auto_trim(g_osc), .test_rx(g_rx),
        .test_tx(g_tx), .test_advanced(g_adv), .endwait_all(g_endw),
        .bus_sel(g_bus), .busy(g_busy), .done(g_done), .error(g_err), .phase(g_phase));

    // Expected outputs for a phase code and bus number.
    function automatic logic [16:0] expVec(input int ph, input int bus);
        logic is_busy;
        logic [4:0] b;
        is_busy = !(ph == 0 || ph == 7 || ph == 8);
        b = is_busy ? 5'(bus) : 5'd0;
        return {4'(ph), b, ph == 1, ph == 2, ph == 5, ph == 6, ph == 3, is_busy, ph == 7, ph == 8};
    endfunction

    task automatic stepCycle();
        @(posedge clk_40_m);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int ph, input int bus);
        logic [16:0] obs, exp_v;
        obs   = {phase, bus_sel, osc_auto_trim, test_rx, test_tx, test_advanced,
                 endwait_all, busy, done, error};
        exp_v = expVec(ph, bus);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic checkG0(input string tag, input int ph, input int bus);
        checks++;
        assert ({g_phase, g_bus, g_err} === {4'(ph), 5'(bus), 1'b0}) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h/%0d expected=%0d/%0d", tag, g_phase, g_bus, ph, bus);
        end
    endtask

    task automatic clearInputs();
        start = 0; trim_done = 0; test_rx_end = 0; test_tx_end = 0; costum_msg_end = 0;
    endtask

    task automatic setEnd(input int ph, input logic v);
        case (ph)
            1: trim_done = v;
            2: test_rx_end = v;
            5: test_tx_end = v;
            6: costum_msg_end = v;
            default: ;
        endcase
    endtask

    // Stay n cycles in phase ph; the end input is raised in cycle n when fire=1.
    task automatic doPhase(input int ph, input int bus, input int n, input bit fire, input bit stray);
        for (int i = 1; i <= n; i++) begin
            checkOutput($sformatf("ph%0d_bus%0d_cyc%0d", ph, bus, i), ph, bus);
            if (stray && i < n) begin
                start = 1'($urandom); trim_done = 1'($urandom); test_rx_end = 1'($urandom);
                test_tx_end = 1'($urandom); costum_msg_end = 1'($urandom);
                setEnd(ph, 1'b0);
            end else begin
                clearInputs();
                if (i == n) setEnd(ph, fire);
            end
            stepCycle();
        end
        clearInputs();
    endtask

    function automatic int pickDur(input int dur);
        return (dur == 0) ? int'($urandom_range(TO, 1)) : dur;
    endfunction

    // One full run; to_bus withholds test_tx_end on that bus, rst_bus resets mid-GAP.
    task automatic applyStimulus(input bit trim, input bit adv, input bit stray, input int to_bus,
                                 input int rst_bus, input int dur, input int trim_n);
        checkOutput("idle_before_start", 0, 0);
        trim_en = trim; adv_en = adv; start = 1;
        stepCycle();
        start = 0;
        if (trim) doPhase(1, 0, pickDur(trim_n), 1, stray);
        for (int b = 1; b <= NB; b++) begin
            doPhase(2, b, pickDur(dur), 1, stray);
            checkOutput($sformatf("endwait_bus%0d", b), 3, b);
            stepCycle();
            for (int g = 0; g < GAP; g++) begin
                if (b == rst_bus && g == 1) begin
                    rst = 0;
                    stepCycle();
                    checkOutput("reset_mid_gap", 0, 0);
                    rst = 1;
                    return;
                end
                checkOutput($sformatf("gap_bus%0d_cyc%0d", b, g), 4, b);
                stepCycle();
            end
            if (b == to_bus) begin
                doPhase(5, b, TO, 0, stray);
                for (int k = 0; k < 100; k++) begin
                    checkOutput($sformatf("err_hold_%0d", k), 8, 0);
                    start = 1'($urandom); test_rx_end = 1'($urandom); test_tx_end = 1'($urandom);
                    stepCycle();
                end
                clearInputs();
                rst = 0;
                stepCycle();
                checkOutput("reset_from_err", 0, 0);
                rst = 1;
                return;
            end
            doPhase(5, b, pickDur(dur), 1, stray);
            if (adv) doPhase(6, b, pickDur(dur), 1, stray);
        end
        checkOutput("done_pulse", 7, 0);
        stepCycle();
        checkOutput("idle_after_done", 0, 0);
    endtask

    initial begin
        rst = 0;
        repeat (3) stepCycle();
        checkOutput("reset_state", 0, 0);
        rst = 1;
        stepCycle();

        // Zero-gap build: ENDWAIT goes straight to TX.
        checkG0("g0_idle", 0, 0);
        g_start = 1; stepCycle(); g_start = 0;
        for (int b = 1; b <= NB; b++) begin
            checkG0($sformatf("g0_rx_bus%0d", b), 2, b);
            g_rx_end = 1; stepCycle(); g_rx_end = 0;
            checkG0($sformatf("g0_endwait_bus%0d", b), 3, b);
            stepCycle();
            checkG0($sformatf("g0_tx_bus%0d", b), 5, b);
            g_tx_end = 1; stepCycle(); g_tx_end = 0;
        end
        checkG0("g0_done", 7, 0);
        stepCycle();
        checkG0("g0_idle_after", 0, 0);

        $display("[TB] basic run");
        applyStimulus(0, 0, 0, 0, 0, 10, 0);
        $display("[TB] trim and advanced run");
        applyStimulus(1, 1, 0, 0, 0, 0, 5);
        $display("[TB] watchdog on bus 2 TX");
        applyStimulus(0, 1, 0, 2, 0, 0, 0);
        $display("[TB] timeout tie run");
        applyStimulus(1, 1, 0, 0, 0, TO, TO);
        $display("[TB] stray pulse run");
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        $display("[TB] reset during GAP on bus 2");
        applyStimulus(0, 0, 0, 0, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        $display("[TB] randomized runs");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
